pio_event_ctrl: RTL
===================

PIO_EVENT_CTRL -- requirements
Module: pio_event_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8: switch PIO data width.
REQ-002 SHALL have parameter MASK_INIT, default all-ones (WIDTH bits): irq_mask value written after reset.
REQ-003 SHALL have port clk  in  1  clock; all state on rising edge.
REQ-004 SHALL have port reset_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port pio_irq  in  1  interrupt from switch PIO.
REQ-006 SHALL have port pio_address  out  2  PIO register select: 0=data, 2=irq_mask, 3=edge_capture.
REQ-007 SHALL have port pio_chipselect  out  1  PIO access strobe.
REQ-008 SHALL have port pio_write_n  out  1  active-low PIO write.
REQ-009 SHALL have port pio_writedata  out  32  PIO write data.
REQ-010 SHALL have port pio_readdata  in  32  PIO read data, registered, valid 1 cycle after address presented.
REQ-011 SHALL have port cfg_mask_wr  in  1  one-cycle request to reprogram irq_mask.
REQ-012 SHALL have port cfg_mask  in  WIDTH  new mask value.
REQ-013 SHALL have port evt_valid  out  1  event available.
REQ-014 SHALL have port evt_ready  in  1  consumer accepts event.
REQ-015 SHALL have port evt_edges  out  WIDTH  captured edge bits.
REQ-016 SHALL have port evt_level  out  WIDTH  switch levels sampled after clear.
REQ-017 SHALL have port evt_count  out  16  accepted-event counter.
REQ-018 SHALL have port busy  out  1  high whenever FSM not in IDLE.

Function
REQ-019 SHALL implement FSM states INIT, IDLE, MASK_WR, RD_CAP, WAIT_CAP, CLR, RD_DAT, WAIT_DAT, EMIT.
REQ-020 INIT: one write cycle, address 2, writedata = zero-extended MASK_INIT; next IDLE.
REQ-021 IDLE: cfg_mask_wr pending -> MASK_WR (priority over irq); else pio_irq=1 -> RD_CAP; else stay.
REQ-022 cfg_mask_wr pulse arriving in any state SHALL be latched (pending flag + value, later pulse overwrites value) and serviced on next IDLE.
REQ-023 MASK_WR: one write cycle, address 2, latched mask; clears pending flag; next IDLE.
REQ-024 RD_CAP: chipselect=1, write_n=1, address 3 for one cycle; next WAIT_CAP.
REQ-025 WAIT_CAP: register pio_readdata[WIDTH-1:0] as edges; if zero (spurious) -> IDLE, else CLR.
REQ-026 CLR: one write cycle, address 3, writedata all-ones; next RD_DAT.
REQ-027 RD_DAT/WAIT_DAT: read address 0, register level in WAIT_DAT; next EMIT.
REQ-028 EMIT: evt_valid=1, evt_edges/evt_level stable; on evt_ready=1 -> evt_count+1 (wraps FFFF->0000), IDLE.
REQ-029 evt_valid SHALL not drop without evt_ready; evt_ready while evt_valid=0 SHALL be ignored.
REQ-030 Outside write/read states: chipselect=0, write_n=1, address=0, writedata=0.
REQ-031 Minimum irq-to-evt_valid latency SHALL be 7 cycles (IDLE seeing irq = cycle 0, evt_valid at cycle 7).
REQ-032 Edges arriving between RD_CAP and CLR are lost by design; edges after CLR re-raise pio_irq and produce a new event.

Reset
REQ-033 reset_n low SHALL force state INIT, pending flag 0, evt_valid 0, evt_edges 0, evt_level 0, evt_count 0, busy 1, chipselect 0, write_n 1, address 0, writedata 0.
REQ-034 Reset mid-sequence SHALL abandon the sequence without completing any PIO access; after release INIT rewrites MASK_INIT.

Structure
REQ-035 Shared package pio_pkg SHALL hold FSM state enum and PIO register offsets (DATA=0, IRQ_MASK=2, EDGE_CAP=3).
REQ-036 Single flat module; no sub-module.

Verification
REQ-037 Reset release, WIDTH=8 -> first cycle after release: write address 2 data 0x000000FF, then IDLE, busy=0.
REQ-038 pio_irq=1, readdata 0x04 at edge_capture, 0x05 at data, evt_ready=1 -> evt_edges=0x04, evt_level=0x05, evt_valid at cycle 7, evt_count=1.
REQ-039 evt_ready held low 20 cycles in EMIT -> evt_valid and outputs stable, no PIO access, count unchanged until ready.
REQ-040 Edge_capture read returns 0x00 -> no CLR write, no event, return to IDLE.
REQ-041 cfg_mask_wr=1 (0x0F) in same cycle as pio_irq in IDLE -> mask write 0x0F first, then capture sequence; cfg_mask_wr pulse during EMIT is serviced after acceptance.
REQ-042 evt_count at 0xFFFF plus one accepted event -> 0x0000; reset_n low during WAIT_DAT -> all outputs at REQ-033 values same cycle.

Source files
------------

// File: rtl/pio_pkg.sv
// Shared definitions for the switch-PIO event controller: FSM states and the
// PIO register offsets it touches.
package pio_pkg;

    typedef enum logic [3:0] {
        INIT,
        IDLE,
        MASK_WR,
        RD_CAP,
        WAIT_CAP,
        CLR,
        RD_DAT,
        WAIT_DAT,
        EMIT
    } pio_state_e;

    localparam logic [1:0] PIO_DATA     = 2'd0;
    localparam logic [1:0] PIO_IRQ_MASK = 2'd2;
    localparam logic [1:0] PIO_EDGE_CAP = 2'd3;

endpackage

// File: rtl/pio_event_ctrl.sv
// Services the switch PIO interrupt: reads and clears edge_capture, samples the
// switch levels and hands the result to a consumer as a valid/ready event.
module pio_event_ctrl
    import pio_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] MASK_INIT = '1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             pio_irq,
    output logic [1:0]       pio_address,
    output logic             pio_chipselect,
    output logic             pio_write_n,
    output logic [31:0]      pio_writedata,
    input  logic [31:0]      pio_readdata,
    input  logic             cfg_mask_wr,
    input  logic [WIDTH-1:0] cfg_mask,
    // evt_valid rises only after edges/level are registered, then holds with
    // stable data until a cycle with evt_valid && evt_ready; ready alone is ignored.
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [WIDTH-1:0] evt_edges,
    output logic [WIDTH-1:0] evt_level,
    output logic [15:0]      evt_count,
    output logic             busy,
    output pio_state_e       dbg_state_o
);

    pio_state_e       state_q, state_d;
    logic             armed_q;
    logic             pend_q;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] edges_q;
    logic [WIDTH-1:0] level_q;
    logic             evt_valid_q;
    logic [15:0]      count_q;
    logic             unused_rd;

    assign unused_rd = ^pio_readdata;

    // armed_q keeps INIT silent until the first clock after reset release, so an
    // asserted reset never shows a PIO access on the bus.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= INIT;
            armed_q     <= 1'b0;
            pend_q      <= 1'b0;
            mask_q      <= MASK_INIT;
            edges_q     <= '0;
            level_q     <= '0;
            evt_valid_q <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q <= state_d;
            armed_q <= 1'b1;
            if (cfg_mask_wr) begin
                pend_q <= 1'b1;
                mask_q <= cfg_mask;
            end else if (state_q == MASK_WR) begin
                pend_q <= 1'b0;
            end
            if (state_q == WAIT_CAP) edges_q <= pio_readdata[WIDTH-1:0];
            if (state_q == WAIT_DAT) level_q <= pio_readdata[WIDTH-1:0];
            // First EMIT cycle only raises valid; acceptance needs valid already high.
            if (state_q == EMIT) begin
                if (!evt_valid_q) begin
                    evt_valid_q <= 1'b1;
                end else if (evt_ready) begin
                    evt_valid_q <= 1'b0;
                    count_q     <= count_q + 16'd1;
                end
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        pio_chipselect = 1'b0;
        pio_write_n    = 1'b1;
        pio_address    = PIO_DATA;
        pio_writedata  = '0;
        unique case (state_q)
            INIT: begin
                if (armed_q) begin
                    pio_chipselect = 1'b1;
                    pio_write_n    = 1'b0;
                    pio_address    = PIO_IRQ_MASK;
                    pio_writedata  = 32'(MASK_INIT);
                    state_d        = IDLE;
                end
            end
            IDLE: begin
                // A mask request seen this very cycle already wins over the irq.
                if (pend_q || cfg_mask_wr) state_d = MASK_WR;
                else if (pio_irq)          state_d = RD_CAP;
            end
            MASK_WR: begin
                pio_chipselect = 1'b1;
                pio_write_n    = 1'b0;
                pio_address    = PIO_IRQ_MASK;
                pio_writedata  = 32'(mask_q);
                state_d        = IDLE;
            end
            RD_CAP: begin
                pio_chipselect = 1'b1;
                pio_address    = PIO_EDGE_CAP;
                state_d        = WAIT_CAP;
            end
            WAIT_CAP: begin
                state_d = (pio_readdata[WIDTH-1:0] == '0) ? IDLE : CLR;
            end
            CLR: begin
                pio_chipselect = 1'b1;
                pio_write_n    = 1'b0;
                pio_address    = PIO_EDGE_CAP;
                pio_writedata  = 32'hFFFF_FFFF;
                state_d        = RD_DAT;
            end
            RD_DAT: begin
                pio_chipselect = 1'b1;
                pio_address    = PIO_DATA;
                state_d        = WAIT_DAT;
            end
            WAIT_DAT: state_d = EMIT;
            EMIT: begin
                if (evt_valid_q && evt_ready) state_d = IDLE;
            end
            default: state_d = INIT;
        endcase
    end

    assign evt_valid   = evt_valid_q;
    assign evt_edges   = edges_q;
    assign evt_level   = level_q;
    assign evt_count   = count_q;
    assign busy        = (state_q != IDLE);
    assign dbg_state_o = state_q;

endmodule
